// File: rtl/result_drain_quant_if.sv
// result_drain_quant_if: result-row handshake from systolic_array plus the output SRAM write port.
interface result_drain_quant_if #(
   parameter int ARRAY_SIZE = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                             result_valid;
   logic [ARRAY_SIZE*ACC_WIDTH-1:0]  result_data;
   logic                             result_ready;
   logic                             sram_wr_en;
   logic [ADDR_WIDTH-1:0]            sram_wr_addr;
   logic [ARRAY_SIZE*OUT_WIDTH-1:0]  sram_wr_data;
   logic                             sram_wr_ready;
   modport master (
      output result_valid, result_data, sram_wr_ready,
      input  result_ready, sram_wr_en, sram_wr_addr, sram_wr_data
   );
   modport slave (
      input  result_valid, result_data, sram_wr_ready,
      output result_ready, sram_wr_en, sram_wr_addr, sram_wr_data
   );
endinterface

// File: rtl/result_drain_quant.sv
// result_drain_quant: requantizes systolic_array result rows and writes them to consecutive SRAM words.
module result_drain_quant #(
   parameter int ARRAY_SIZE = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [15:0]           cfg_rows,
   input  logic [4:0]            cfg_shift,
   input  logic                  cfg_relu,
   output logic                  busy,
   output logic                  done,
   result_drain_quant_if.slave   bus
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FIN = 2'd3;
   localparam int RW = ARRAY_SIZE * ACC_WIDTH;
   localparam int QW = ARRAY_SIZE * OUT_WIDTH;
   localparam logic signed [ACC_WIDTH:0] HI = (ACC_WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH:0] LO = (ACC_WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));
   logic [1:0]            state_q, state_d;
   logic [15:0]           rows_q, rows_d, acnt_q, acnt_d, wcnt_q, wcnt_d;
   logic [4:0]            shift_q, shift_d;
   logic                  relu_q, relu_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, s2_addr_q, s2_addr_d;
   logic                  s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic [RW-1:0]         s1_data_q, s1_data_d;
   logic [QW-1:0]         s2_data_q, s2_data_d;
   logic                  adv, accept, wr_done;
   // one extra bit keeps the rounding add from overflowing at the accumulator extremes
   function automatic logic [OUT_WIDTH-1:0] quant(input logic [ACC_WIDTH-1:0] a, input logic [4:0] sh,
                                                  input logic relu);
      logic signed [ACC_WIDTH:0] x, y;
      logic [ACC_WIDTH:0]        half;
      half = ((ACC_WIDTH+1)'(1) << sh) >> 1;
      x = $signed({a[ACC_WIDTH-1], a});
      y = (x + $signed(half)) >>> sh;
      y = (relu && y < 0) ? '0 : y;
      return y > HI ? HI[OUT_WIDTH-1:0] : y < LO ? LO[OUT_WIDTH-1:0] : y[OUT_WIDTH-1:0];
   endfunction
   assign adv              = !s2_v_q || bus.sram_wr_ready;
   assign accept           = bus.result_valid && bus.result_ready;
   assign wr_done          = s2_v_q && bus.sram_wr_ready;
   assign bus.result_ready = state_q == RUN && acnt_q < rows_q && (!s1_v_q || adv);
   assign bus.sram_wr_en   = s2_v_q;
   assign bus.sram_wr_addr = s2_addr_q;
   assign bus.sram_wr_data = s2_data_q;
   assign busy             = state_q == RUN || state_q == DRAIN;
   assign done             = state_q == FIN;
   always_comb begin
      state_d   = state_q;
      rows_d    = rows_q;
      shift_d   = shift_q;
      relu_d    = relu_q;
      addr_d    = addr_q;
      acnt_d    = acnt_q + 16'(accept);
      wcnt_d    = wcnt_q + 16'(wr_done);
      s1_v_d    = accept || (s1_v_q && !adv);
      s1_data_d = accept ? bus.result_data : s1_data_q;
      s2_v_d    = adv ? s1_v_q : s2_v_q;
      s2_data_d = s2_data_q;
      s2_addr_d = s2_addr_q;
      if (adv && s1_v_q) begin
         for (int i = 0; i < ARRAY_SIZE; i++)
            s2_data_d[i*OUT_WIDTH +: OUT_WIDTH] = quant(s1_data_q[i*ACC_WIDTH +: ACC_WIDTH], shift_q, relu_q);
         s2_addr_d = addr_q;
         addr_d    = addr_q + ADDR_WIDTH'(1);
      end
      case (state_q)
         IDLE: if (start) begin
            rows_d  = cfg_rows;
            shift_d = cfg_shift;
            relu_d  = cfg_relu;
            addr_d  = cfg_base_addr;
            acnt_d  = '0;
            wcnt_d  = '0;
            state_d = cfg_rows == '0 ? FIN : RUN;
         end
         RUN:     state_d = acnt_d == rows_q ? DRAIN : RUN;
         DRAIN:   state_d = wcnt_d == rows_q ? FIN : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q   <= IDLE;
         rows_q    <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         addr_q    <= '0;
         acnt_q    <= '0;
         wcnt_q    <= '0;
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rows_q    <= rows_d;
         shift_q   <= shift_d;
         relu_q    <= relu_d;
         addr_q    <= addr_d;
         acnt_q    <= acnt_d;
         wcnt_q    <= wcnt_d;
         s1_v_q    <= s1_v_d;
         s1_data_q <= s1_data_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
         s2_addr_q <= s2_addr_d;
      end
endmodule

// File: tb/tb_result_drain_quant.sv
// tb_result_drain_quant: scoreboard bench for result_drain_quant; expected SRAM writes are queued as rows are offered.
module tb_result_drain_quant;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_relu = 1'b0;
   logic [15:0] cfg_base_addr = '0, cfg_rows = '0;
   logic [4:0]  cfg_shift = '0;
   logic        busy, done;
   int          n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0, n_stall = 0;
   int          cyc = 0, acc_cyc = 0, wr_cyc = 0;
   bit          bp_mode = 0, zero_job = 0, stall_v = 0, prev_hs = 0, prev_en = 0;
   logic [47:0] stall_word, e;
   logic [15:0] exp_addr = '0;
   int          job_shift = 0;
   bit          job_relu = 0;
   logic [127:0] tx_q[$];
   logic [47:0]  exp_q[$];

   result_drain_quant_if bus ();
   result_drain_quant dut (
      .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr), .cfg_rows(cfg_rows),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   // reference requantizer: floor division of (x + half) by 2^sh, then ReLU and clamp
   function automatic logic [7:0] q_model(input longint x, input int sh, input bit relu);
      longint d, t, y;
      if (sh == 0) y = x;
      else begin
         d = longint'(1) << sh;
         t = x + d / 2;
         y = t / d;
         if (t % d != 0 && t < 0) y = y - 1;
      end
      if (relu && y < 0) y = 0;
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      return y[7:0];
   endfunction

   function automatic void set_job(input logic [15:0] base, input int sh, input bit relu);
      exp_addr = base;
      job_shift = sh;
      job_relu = relu;
   endfunction

   function automatic void push_row_exp(input int l0, l1, l2, l3, input logic [31:0] q);
      tx_q.push_back({l3, l2, l1, l0});
      exp_q.push_back({exp_addr, q});
      exp_addr++;
   endfunction

   function automatic void push_row(input int l0, l1, l2, l3);
      push_row_exp(l0, l1, l2, l3, {q_model(l3, job_shift, job_relu), q_model(l2, job_shift, job_relu),
                                    q_model(l1, job_shift, job_relu), q_model(l0, job_shift, job_relu)});
   endfunction

   // row source and SRAM ready driver, updated just after each rising edge
   initial begin
      bus.result_valid = 1'b0;
      bus.result_data = '0;
      bus.sram_wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.result_valid = tx_q.size() > 0;
         bus.result_data = tx_q.size() > 0 ? tx_q[0] : '0;
         bus.sram_wr_ready = bp_mode ? !bus.sram_wr_ready : 1'b1;
      end
   end

   // monitor: pops accepted rows, checks writes against the scoreboard, stall stability and done timing
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         stall_v = 0;
         prev_hs = 0;
         prev_en = 0;
      end else begin
         if (bus.result_valid && bus.result_ready) begin
            acc_cyc = cyc;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
         end
         if (busy && bus.result_valid && !bus.result_ready) n_stall++;
         if (bus.sram_wr_en && !prev_en) wr_cyc = cyc;
         if (bus.sram_wr_en && stall_v) begin
            n_cmp++;
            if ({bus.sram_wr_addr, bus.sram_wr_data} !== stall_word) begin
               n_bad++;
               $display("FAIL stall_hold: got %h, held value %h", {bus.sram_wr_addr, bus.sram_wr_data}, stall_word);
            end
         end
         if (bus.sram_wr_en && bus.sram_wr_ready) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL write_extra: addr %h data %h, no write expected", bus.sram_wr_addr, bus.sram_wr_data);
            end else begin
               e = exp_q.pop_front();
               if ({bus.sram_wr_addr, bus.sram_wr_data} !== e) begin
                  n_bad++;
                  $display("FAIL write: addr/data %h %h, expected %h %h", bus.sram_wr_addr, bus.sram_wr_data,
                           e[47:32], e[31:0]);
               end
            end
         end
         if (done) begin
            n_done++;
            n_cmp++;
            if (prev_hs == zero_job) begin
               n_bad++;
               $display("FAIL done_timing: write handshake in previous cycle %0b, required %0b", prev_hs, !zero_job);
            end
         end
         prev_hs = bus.sram_wr_en && bus.sram_wr_ready;
         prev_en = bus.sram_wr_en;
         stall_v = bus.sram_wr_en && !bus.sram_wr_ready;
         stall_word = {bus.sram_wr_addr, bus.sram_wr_data};
      end
   end

   task automatic start_job(input logic [15:0] base, input logic [15:0] rows, input logic [4:0] sh, input logic relu);
      @(posedge clk);
      #1;
      zero_job = rows == 0;
      start = 1'b1;
      cfg_base_addr = base;
      cfg_rows = rows;
      cfg_shift = sh;
      cfg_relu = relu;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0;
      d0 = n_done;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (n_done != d0) break;
      end
      n_cmp++;
      if (n_done == d0) begin
         n_bad++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_status: busy,done=%b required 00", {busy, done});
      end
      n_cmp++;
      if ({bus.result_ready, bus.sram_wr_en} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_strobes: ready,wr_en=%b required 00", {bus.result_ready, bus.sram_wr_en});
      end
      n_cmp++;
      if ({bus.sram_wr_addr, bus.sram_wr_data} !== 48'h0) begin
         n_bad++;
         $display("FAIL reset_bus: addr %h data %h required 0", bus.sram_wr_addr, bus.sram_wr_data);
      end
   endtask

   task automatic test_identity();
      int w0, d0;
      w0 = n_wr;
      d0 = n_done;
      set_job(16'h0010, 0, 0);
      start_job(16'h0010, 16'd4, 5'd0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL identity_busy: busy=%b required 1", busy);
      end
      push_row_exp(1, 2, 3, 4, 32'h04030201);
      push_row_exp(5, 6, 7, 8, 32'h08070605);
      push_row_exp(9, 10, 11, 12, 32'h0C0B0A09);
      push_row_exp(13, 14, 15, 16, 32'h100F0E0D);
      wait_done("identity", 60);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (n_wr - w0 != 4 || n_done - d0 != 1) begin
         n_bad++;
         $display("FAIL identity_counts: writes %0d dones %0d, required 4 and 1", n_wr - w0, n_done - d0);
      end
      n_cmp++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL identity_end: busy=%b pending=%0d, required 0 and 0", busy, exp_q.size());
      end
   endtask

   task automatic test_rounding();
      set_job(16'h0030, 2, 0);
      start_job(16'h0030, 16'd1, 5'd2, 1'b0);
      push_row_exp(6, -6, 5, -7, 32'hFE01FF02);
      wait_done("rounding", 30);
      n_cmp++;
      if (wr_cyc - acc_cyc != 2) begin
         n_bad++;
         $display("FAIL latency: accept-to-write %0d cycles, required 2", wr_cyc - acc_cyc);
      end
   endtask

   task automatic test_sat_relu();
      set_job(16'h0040, 0, 0);
      start_job(16'h0040, 16'd1, 5'd0, 1'b0);
      push_row_exp(300, -300, 127, -5, 32'hFB7F807F);
      wait_done("sat", 30);
      set_job(16'h0041, 0, 1);
      start_job(16'h0041, 16'd1, 5'd0, 1'b1);
      push_row_exp(300, -300, 127, -5, 32'h007F007F);
      wait_done("relu", 30);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sat_relu_pending: %0d writes missing, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int w0, s0;
      w0 = n_wr;
      s0 = n_stall;
      set_job(16'h0100, 3, 0);
      bp_mode = 1;
      start_job(16'h0100, 16'd4, 5'd3, 1'b0);
      for (int r = 0; r < 4; r++)
         push_row(int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
                  int'($urandom_range(4000)) - 2000, -2000 + 1000 * r);
      wait_done("backpressure", 80);
      bp_mode = 0;
      n_cmp++;
      if (n_wr - w0 != 4 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL bp_writes: writes %0d pending %0d, required 4 and 0", n_wr - w0, exp_q.size());
      end
      n_cmp++;
      if (n_stall - s0 == 0) begin
         n_bad++;
         $display("FAIL bp_stall: result_ready never stalled, required at least one stall");
      end
   endtask

   task automatic test_rows_zero();
      int w0, d0;
      w0 = n_wr;
      d0 = n_done;
      start_job(16'h0055, 16'd0, 5'd0, 1'b0);
      wait_done("rows_zero", 4);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (n_wr != w0 || n_done - d0 != 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rows_zero: writes %0d dones %0d busy %b, required 0 1 0", n_wr - w0, n_done - d0, busy);
      end
   endtask

   task automatic test_start_busy();
      int d0;
      d0 = n_done;
      set_job(16'h0060, 0, 0);
      start_job(16'h0060, 16'd2, 5'd0, 1'b0);
      start_job(16'h0080, 16'd5, 5'd3, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL start_busy_state: busy=%b required 1", busy);
      end
      push_row(-3, 100, -100, 7);
      push_row(1, -1, 2, -2);
      wait_done("start_busy", 40);
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (n_done - d0 != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL start_busy_end: dones %0d busy %b pending %0d, required 1 0 0", n_done - d0, busy, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      int w0;
      w0 = n_wr;
      set_job(16'hFFFF, 0, 0);
      push_row(11, 22, 33, 44);
      push_row(-11, -22, -33, -44);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.result_ready !== 1'b0 || n_wr != w0 || tx_q.size() != 2) begin
         n_bad++;
         $display("FAIL idle_hold: ready=%b writes %0d queued %0d, required 0 0 2", bus.result_ready, n_wr - w0, tx_q.size());
      end
      start_job(16'hFFFF, 16'd2, 5'd0, 1'b0);
      wait_done("wrap", 40);
      n_cmp++;
      if (n_wr - w0 != 2 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL wrap_counts: writes %0d pending %0d, required 2 and 0", n_wr - w0, exp_q.size());
      end
   endtask

   task automatic test_reset_midjob();
      int w0, d0, i;
      w0 = n_wr;
      set_job(16'h0200, 0, 0);
      start_job(16'h0200, 16'd4, 5'd0, 1'b0);
      for (int r = 0; r < 4; r++) push_row(r, r + 1, r + 2, r + 3);
      for (i = 0; i < 30 && n_wr - w0 < 2; i++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (n_wr - w0 < 2) begin
         n_bad++;
         $display("FAIL midjob_progress: %0d writes before reset, required 2", n_wr - w0);
      end
      rst = 1'b1;
      tx_q.delete();
      exp_q.delete();
      d0 = n_done;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, done, bus.result_ready, bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data} !== 52'h0) begin
         n_bad++;
         $display("FAIL midjob_reset: busy %b done %b ready %b wr_en %b addr %h data %h, required all 0",
                  busy, done, bus.result_ready, bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      if (n_done != d0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midjob_abandon: dones %0d busy %b, required 0 and 0", n_done - d0, busy);
      end
      w0 = n_wr;
      set_job(16'h0020, 1, 1);
      start_job(16'h0020, 16'd2, 5'd1, 1'b1);
      push_row(-3, 7, 1000, -1000);
      push_row(5, -5, 255, 256);
      wait_done("fresh_job", 40);
      n_cmp++;
      if (n_wr - w0 != 2 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL fresh_job: writes %0d pending %0d, required 2 and 0", n_wr - w0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_rounding();
      test_sat_relu();
      test_backpressure();
      test_rows_zero();
      test_start_busy();
      test_wrap();
      test_reset_midjob();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
